// File: rtl/pixel_write_arbiter.sv
// Pixel RAM write-port arbiter: round-robin between two valid/ready writers,
// plus a clear sequencer that sweeps 0..CLEAR_DEPTH-1 with a fill value and
// owns the write port while it runs. All write-port outputs are registered.
module pixel_write_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16,
    parameter int CLEAR_DEPTH = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_a_valid,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_a_ready,
    input  logic              i_b_valid,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_data,
    output logic              o_b_ready,
    input  logic              i_clear_start,
    input  logic [DATA_W-1:0] i_clear_value,
    output logic              o_clear_busy,
    output logic              o_clear_done,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic [DATA_W-1:0] o_w_data,
    output logic              o_w_enable
);
    // One extra bit so a full 2^ADDR_W sweep never wraps before the last address.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLEAR_DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic              last_b_q, last_b_d;   // 1: B won last, so A wins next contention
    wr_t               wr_q, wr_d;
    logic              done_q, done_d;
    logic              a_grant, b_grant;

    // Next-state, arbitration and write-port selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fill_d   = fill_q;
        last_b_d = last_b_q;
        wr_d     = wr_q;
        wr_d.en  = 1'b0;
        done_d   = 1'b0;
        a_grant  = 1'b0;
        b_grant  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_clear_start) begin
                    // Clear takes priority: no requester is granted this cycle.
                    state_d = CLEAR;
                    cnt_d   = '0;
                    fill_d  = i_clear_value;
                end else begin
                    a_grant = i_a_valid && (!i_b_valid || last_b_q);
                    b_grant = i_b_valid && !a_grant;
                    if (a_grant) begin
                        wr_d.en   = 1'b1;
                        wr_d.addr = i_a_addr;
                        wr_d.data = i_a_data;
                        last_b_d  = 1'b0;
                    end else if (b_grant) begin
                        wr_d.en   = 1'b1;
                        wr_d.addr = i_b_addr;
                        wr_d.data = i_b_data;
                        last_b_d  = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_d.en   = 1'b1;
                wr_d.addr = cnt_q[ADDR_W-1:0];
                wr_d.data = fill_q;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            fill_q   <= '0;
            last_b_q <= 1'b1;
            wr_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            last_b_q <= last_b_d;
            wr_q     <= wr_d;
            done_q   <= done_d;
        end
    end

    // A handshake during reset would be dropped, so never advertise ready then.
    assign o_a_ready    = a_grant && i_rst_n;
    assign o_b_ready    = b_grant && i_rst_n;
    assign o_clear_busy = (state_q == CLEAR);
    assign o_clear_done = done_q;
    assign o_w_enable   = wr_q.en;
    assign o_w_addr     = wr_q.addr;
    assign o_w_data     = wr_q.data;
endmodule
